// File: rtl/fnd_scan_controller_pkg.sv
// Shared types and constants for the 4-digit FND scan controller.
package fnd_scan_controller_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned SEL_W      = 2;
  localparam int unsigned BCD_W      = NUM_DIGITS * DIGIT_W;
  localparam int unsigned BCD_MAX    = 9999;

  typedef enum logic [1:0] {
    CONV_IDLE  = 2'd0,
    CONV_SHIFT = 2'd1,
    CONV_DONE  = 2'd2
  } conv_state_e;

  // Double-dabble correction: add 3 to every nibble that is 5 or more.
  function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] acc);
    logic [BCD_W-1:0] res;
    res = acc;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (acc[i*DIGIT_W +: DIGIT_W] >= 4'd5) begin
        res[i*DIGIT_W +: DIGIT_W] = acc[i*DIGIT_W +: DIGIT_W] + 4'd3;
      end
    end
    return res;
  endfunction

  // Position of the most significant nonzero digit (0 when the value is 0).
  function automatic logic [SEL_W-1:0] msd_index(input logic [BCD_W-1:0] bcd);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (bcd[i*DIGIT_W +: DIGIT_W] != 4'd0) begin
        idx = SEL_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/fnd_bin2bcd.sv
// Iterative binary-to-BCD converter (double dabble), one bit per cycle.
module fnd_bin2bcd
  import fnd_scan_controller_pkg::*;
#(
  parameter int unsigned CONV_BITS = 14
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [CONV_BITS-1:0] i_value,
  input  logic                 i_load,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_ovf,
  output logic [BCD_W-1:0]     o_bcd
);

  localparam int unsigned CNT_W = $clog2(CONV_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CONV_BITS - 1);
  localparam logic [CONV_BITS-1:0] CLAMP_VAL = CONV_BITS'(BCD_MAX);

  conv_state_e          state_q, state_d;
  logic [CONV_BITS-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 over_c;
  logic [BCD_W-1:0]     acc_adj;

  assign over_c  = (64'(i_value) > 64'(BCD_MAX));
  assign acc_adj = bcd_add3(acc_q);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= CONV_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      CONV_IDLE:  if (i_load) state_d = CONV_SHIFT;
      CONV_SHIFT: if (cnt_q == LAST_CNT) state_d = CONV_DONE;
      CONV_DONE:  state_d = CONV_IDLE;
      default:    state_d = CONV_IDLE;
    endcase
  end

  // Datapath and flag next values.
  always_comb begin
    bin_d  = bin_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    busy_d = (state_d != CONV_IDLE);
    done_d = (state_d == CONV_DONE);
    case (state_q)
      CONV_IDLE: begin
        if (i_load) begin
          bin_d = over_c ? CLAMP_VAL : i_value;
          acc_d = '0;
          cnt_d = '0;
          ovf_d = over_c;
        end
      end
      CONV_SHIFT: begin
        acc_d = {acc_adj[BCD_W-2:0], bin_q[CONV_BITS-1]};
        bin_d = bin_q << 1;
        cnt_d = cnt_q + CNT_W'(1);
      end
      default: ;
    endcase
  end

  // Datapath and flag registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      bin_q  <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign o_busy = busy_q;
  assign o_done = done_q;
  assign o_ovf  = ovf_q;
  assign o_bcd  = acc_q;

endmodule

// File: rtl/fnd_scan_controller.sv
// 4-digit FND scan controller: binary load, BCD conversion, digit scanning, blanking.
module fnd_scan_controller
  import fnd_scan_controller_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 100000,
  parameter int unsigned CONV_BITS = 14
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [CONV_BITS-1:0] i_value,
  input  logic                 i_load,
  input  logic                 i_en,
  input  logic                 i_blank_lz,
  output logic                 o_busy,
  output logic                 o_ovf,
  output logic [SEL_W-1:0]     o_digitSelect,
  output logic [DIGIT_W-1:0]   o_value,
  output logic                 o_en
);

  localparam int unsigned PRE_W = $clog2(CLK_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [BCD_W-1:0] disp_q, disp_d;
  logic             conv_done;
  logic [BCD_W-1:0] conv_bcd;
  logic             pre_wrap;
  logic             lz_show;

  fnd_bin2bcd #(
    .CONV_BITS (CONV_BITS)
  ) u_bin2bcd (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_value (i_value),
    .i_load  (i_load),
    .o_busy  (o_busy),
    .o_done  (conv_done),
    .o_ovf   (o_ovf),
    .o_bcd   (conv_bcd)
  );

  // Prescaler, scan position and display register next values.
  always_comb begin
    pre_wrap = (pre_q == PRE_LAST);
    pre_d    = pre_wrap ? '0 : pre_q + PRE_W'(1);
    sel_d    = pre_wrap ? sel_q + SEL_W'(1) : sel_q;
    disp_d   = conv_done ? conv_bcd : disp_q;
  end

  // Scan and display registers; the display only changes as a whole word.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pre_q  <= '0;
      sel_q  <= '0;
      disp_q <= '0;
    end else begin
      pre_q  <= pre_d;
      sel_q  <= sel_d;
      disp_q <= disp_d;
    end
  end

  // Digit mux and leading-zero blanking from registered state.
  always_comb begin
    lz_show = !i_blank_lz || (sel_q <= msd_index(disp_q));
    o_value = disp_q[{sel_q, 2'b00} +: DIGIT_W];
    o_en    = i_en && lz_show;
  end

  assign o_digitSelect = sel_q;

endmodule
